sprite_draw_engine: RTL and testbench
=====================================

Name: sprite_draw_engine

Overview:
Parametrised pixel-plotting engine for the running-man VGA game. It sits between the game-control FSM and the VGA adapter. It executes three commands: draw the floor bands, draw the man sprite, and erase the man sprite. Each command streams one candidate pixel per clock, with a plot strobe, until a done pulse.
It generalises the fixed 26-pixel man/floor datapath in four ways:
- ROM-bitmap sprites of configurable size and style count.
- Configurable floor geometry.
- Transparent-pixel skipping and screen-edge clipping.
- A valid/ready command handshake.

Parameters:
SCREEN_W, 160, screen width in pixels
SCREEN_H, 120, screen height in pixels
XW, 8, x coordinate width
YW, 7, y coordinate width
SPRITE_W, 8, sprite bitmap width
SPRITE_H, 8, sprite bitmap height
NUM_STYLES, 2, sprite styles (0 = crouch, 1 = normal)
NUM_FLOORS, 3, number of floor bands
FLOOR_Y0, 35, top row of first floor
FLOOR_PITCH, 40, row distance between floor tops
FLOOR_T, 5, floor thickness in rows
CW, 3, colour width
FLOOR_COLOR, 3'b101, floor colour
MAN_COLOR, 3'b111, sprite colour
BG_COLOR, 3'b000, erase colour
X_INIT, 30, reset x origin
Y_INIT, 108, reset y origin

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  engine idle; accepts a command this cycle
cmd_op  in  2  0 DRAW_FLOORS, 1 DRAW_SPRITE, 2 ERASE_SPRITE, 3 NOP
x_in  in  XW  new sprite x origin
y_in  in  YW  new sprite y origin
ld_pos  in  1  load x_in/y_in into origin registers
style_in  in  $clog2(NUM_STYLES)  new sprite style
ld_style  in  1  load style_in into style register
plot  out  1  write x/y/color to frame buffer this cycle
x  out  XW  pixel x
y  out  YW  pixel y
color  out  CW  pixel colour
busy  out  1  command in progress
done  out  1  one-cycle pulse, command complete

Behaviour:
Reset values:
- plot=0, x=0, y=0, color=0, busy=0, done=0, cmd_ready=1.
- Origin=(X_INIT,Y_INIT), style=1, state IDLE.

Origin/style registers:
- Load on ld_pos/ld_style in any state.
- The engine snapshots origin, style and op at command accept. Later loads do not affect the running command.

FSM states and transitions:
- IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready.
  - DRAW_FLOORS -> FLOOR.
  - DRAW_SPRITE or ERASE_SPRITE -> SPRITE.
  - NOP -> DONE.
- FLOOR: nested counters. col runs 0..SCREEN_W-1, then row 0..FLOOR_T-1, then band 0..NUM_FLOORS-1.
  - Pixel = (col, FLOOR_Y0 + band*FLOOR_PITCH + row), FLOOR_COLOR.
  - Plot suppressed if y >= SCREEN_H.
  - After the last pixel -> DONE.
- SPRITE: row-major scan, col 0..SPRITE_W-1 inner, row 0..SPRITE_H-1 outer.
  - Pixel = (ox+col, oy+row).
  - plot=1 only if the bitmap bit is 1 AND ox+col < SCREEN_W AND oy+row < SCREEN_H.
  - Sums are computed at XW+1 / YW+1 bits so there is no wrap-around.
  - color = MAN_COLOR for draw, BG_COLOR for erase. Erase visits exactly the pixels draw visits.
- DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- busy=1 in FLOOR and SPRITE.

Timing:
- x/y/color/plot are registered.
- Accept at cycle T: first pixel is valid at T+1, last at T+N, done at T+N+1, cmd_ready=1 again at T+N+2.
- N = NUM_FLOORS*FLOOR_T*SCREEN_W for floors, SPRITE_W*SPRITE_H for sprites, 0 for NOP (done at T+1).
- Transparent and clipped pixels still consume a cycle, so latency is deterministic.

Boundary and error conditions:
- cmd_valid while busy: ignored, no queueing.
- Outside FLOOR and SPRITE, plot=0 and x/y/color hold their last values.
- reset mid-command: immediate return to IDLE and the reset values. No done pulse. The partial image is left as drawn.

Decomposition:
- Package draw_pkg: cmd_op encodings (OP_FLOORS, OP_SPRITE, OP_ERASE, OP_NOP), FSM state enum, colour constants.
- Sub-module sprite_rom: combinational lookup (style, row) -> SPRITE_W-bit row bitmap. Style 1 is the normal man, style 0 the crouched man, both 7x7 in the top-left of the 8x8 cell. Unused bits are 0.

Test Plan:
- Reset asserted then released -> cmd_ready=1, busy=0, plot=0. An ERASE at the default origin covers x 30..37, y 108..115.
- DRAW_FLOORS accepted at T:
  - exactly 2400 plots.
  - first pixel (0,35) at T+1, last pixel (159,119) at T+2400.
  - all colour 101, done at T+2401.
  - no plots for rows 40..74 or 80..114.
- ld_pos (30,108), style 1, DRAW_SPRITE -> plot count equals the ROM popcount. Every plotted pixel is inside x 30..37, y 108..115, colour 111. done at T+65.
- ERASE_SPRITE at the same origin -> identical pixel sequence, colour 000.
- Origin x=156 -> no plot with x>=160 (only cols 0..3 may plot), still 64 cycles. Origin y=118 -> only rows 0..1 may plot.
- cmd_valid held during a sprite command -> cmd_ready=0 and no second command. ld_pos mid-command does not change the remaining pixels. reset at pixel 20 -> plot=0 next cycle, no done, cmd_ready=1.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared encodings for the sprite draw engine: command opcodes, FSM states,
// default colours and the man-sprite bitmaps.
package draw_pkg;

  localparam logic [1:0] OP_FLOORS = 2'd0;
  localparam logic [1:0] OP_SPRITE = 2'd1;
  localparam logic [1:0] OP_ERASE  = 2'd2;
  localparam logic [1:0] OP_NOP    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLOOR  = 2'd1,
    ST_SPRITE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [2:0] FLOOR_COLOR_DEF = 3'b101;
  localparam logic [2:0] MAN_COLOR_DEF   = 3'b111;
  localparam logic [2:0] BG_COLOR_DEF    = 3'b000;

  // One 8-bit row of the 7x7 man (bit n = column n); rows 7+ are empty.
  function automatic logic [7:0] man_row(input logic normal, input int unsigned row);
    logic [7:0] r;
    r = '0;
    if (normal) begin
      case (row)
        0, 1:    r = 8'h1C;
        2:       r = 8'h08;
        3:       r = 8'h7F;
        4:       r = 8'h08;
        5:       r = 8'h14;
        6:       r = 8'h22;
        default: r = '0;
      endcase
    end else begin
      case (row)
        2, 3:    r = 8'h1C;
        4:       r = 8'h7F;
        5:       r = 8'h3E;
        6:       r = 8'h63;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Combinational sprite bitmap lookup: (style, row) -> one row of pixels.
// Style 0 is the crouched man, any other style the normal man.
module sprite_rom
  import draw_pkg::*;
#(
  parameter int SPRITE_W   = 8,
  parameter int SPRITE_H   = 8,
  parameter int NUM_STYLES = 2
) (
  input  logic [$clog2(NUM_STYLES)-1:0] style_i,
  input  logic [$clog2(SPRITE_H)-1:0]   row_i,
  output logic [SPRITE_W-1:0]           bits_o
);

  logic [7:0] row8;

  // Fetch the fixed 8-wide bitmap row and fit it to the configured width.
  always_comb begin
    row8   = man_row(style_i != '0, 32'(row_i));
    bits_o = SPRITE_W'(row8);
  end

endmodule

// File: rtl/sprite_draw_engine.sv
// Pixel-plotting engine: streams floor bands, the man sprite, or its erase
// pattern one candidate pixel per clock, with registered plot/x/y/color.
module sprite_draw_engine
  import draw_pkg::*;
#(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int XW          = 8,
  parameter int YW          = 7,
  parameter int SPRITE_W    = 8,
  parameter int SPRITE_H    = 8,
  parameter int NUM_STYLES  = 2,
  parameter int NUM_FLOORS  = 3,
  parameter int FLOOR_Y0    = 35,
  parameter int FLOOR_PITCH = 40,
  parameter int FLOOR_T     = 5,
  parameter int CW          = 3,
  parameter logic [CW-1:0] FLOOR_COLOR = FLOOR_COLOR_DEF,
  parameter logic [CW-1:0] MAN_COLOR   = MAN_COLOR_DEF,
  parameter logic [CW-1:0] BG_COLOR    = BG_COLOR_DEF,
  parameter int X_INIT      = 30,
  parameter int Y_INIT      = 108
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [XW-1:0]                 x_in,
  input  logic [YW-1:0]                 y_in,
  input  logic                          ld_pos,
  input  logic [$clog2(NUM_STYLES)-1:0] style_in,
  input  logic                          ld_style,
  output logic                          plot,
  output logic [XW-1:0]                 x,
  output logic [YW-1:0]                 y,
  output logic [CW-1:0]                 color,
  output logic                          busy,
  output logic                          done
);

  localparam int SW  = $clog2(NUM_STYLES);
  localparam int RW  = $clog2(SPRITE_H);
  localparam int CLW = $clog2(SPRITE_W);
  localparam int BW  = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;

  state_t          state_q, state_d;
  logic [XW-1:0]   ox_q;
  logic [YW-1:0]   oy_q;
  logic [SW-1:0]   style_q;
  logic [XW-1:0]   cox_q, cox_d;
  logic [YW-1:0]   coy_q, coy_d;
  logic [SW-1:0]   cstyle_q, cstyle_d;
  logic            erase_q, erase_d;
  logic [XW-1:0]   col_q, col_d;
  logic [YW-1:0]   row_q, row_d;
  logic [BW-1:0]   band_q, band_d;
  logic            gen_floor, gen_sprite;
  logic            plot_q, plot_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   color_q, color_d;
  logic            done_q, done_d;
  logic [31:0]     fy;
  logic [XW:0]     sx;
  logic [YW:0]     sy;
  logic [SPRITE_W-1:0] rom_bits;

  sprite_rom #(
    .SPRITE_W  (SPRITE_W),
    .SPRITE_H  (SPRITE_H),
    .NUM_STYLES(NUM_STYLES)
  ) u_rom (
    .style_i(cstyle_d),
    .row_i  (row_d[RW-1:0]),
    .bits_o (rom_bits)
  );

  // Origin and style registers, loadable at any time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ox_q    <= XW'(X_INIT);
      oy_q    <= YW'(Y_INIT);
      style_q <= SW'(1);
    end else begin
      if (ld_pos) begin
        ox_q <= x_in;
        oy_q <= y_in;
      end
      if (ld_style) style_q <= style_in;
    end
  end

  // Command sequencing. Counters hold the index of the pixel currently on the
  // outputs; the *_d values select the pixel registered at the next edge, so
  // the first pixel is emitted straight from the accept edge.
  always_comb begin
    state_d    = state_q;
    cox_d      = cox_q;
    coy_d      = coy_q;
    cstyle_d   = cstyle_q;
    erase_d    = erase_q;
    col_d      = col_q;
    row_d      = row_q;
    band_d     = band_q;
    gen_floor  = 1'b0;
    gen_sprite = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cox_d    = ox_q;
          coy_d    = oy_q;
          cstyle_d = style_q;
          erase_d  = (cmd_op == OP_ERASE);
          col_d    = '0;
          row_d    = '0;
          band_d   = '0;
          case (cmd_op)
            OP_FLOORS: begin
              state_d   = ST_FLOOR;
              gen_floor = 1'b1;
            end
            OP_SPRITE, OP_ERASE: begin
              state_d    = ST_SPRITE;
              gen_sprite = 1'b1;
            end
            default: begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      ST_FLOOR: begin
        if (col_q == XW'(SCREEN_W - 1) && row_q == YW'(FLOOR_T - 1) &&
            band_q == BW'(NUM_FLOORS - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          gen_floor = 1'b1;
          if (col_q == XW'(SCREEN_W - 1)) begin
            col_d = '0;
            if (row_q == YW'(FLOOR_T - 1)) begin
              row_d  = '0;
              band_d = band_q + BW'(1);
            end else begin
              row_d = row_q + YW'(1);
            end
          end else begin
            col_d = col_q + XW'(1);
          end
        end
      end
      ST_SPRITE: begin
        if (col_q == XW'(SPRITE_W - 1) && row_q == YW'(SPRITE_H - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          gen_sprite = 1'b1;
          if (col_q == XW'(SPRITE_W - 1)) begin
            col_d = '0;
            row_d = row_q + YW'(1);
          end else begin
            col_d = col_q + XW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pixel generation for the selected next position, with clipping.
  always_comb begin
    plot_d  = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    fy = 32'(FLOOR_Y0) + 32'(band_d) * 32'(FLOOR_PITCH) + 32'(row_d);
    sx = {1'b0, cox_d} + {1'b0, col_d};
    sy = {1'b0, coy_d} + {1'b0, row_d};
    if (gen_floor) begin
      x_d     = col_d;
      y_d     = fy[YW-1:0];
      color_d = FLOOR_COLOR;
      plot_d  = (fy < 32'(SCREEN_H));
    end else if (gen_sprite) begin
      x_d     = sx[XW-1:0];
      y_d     = sy[YW-1:0];
      color_d = erase_q ? BG_COLOR : MAN_COLOR;
      if (state_q == ST_IDLE) color_d = erase_d ? BG_COLOR : MAN_COLOR;
      plot_d  = rom_bits[col_d[CLW-1:0]] && (sx < (XW+1)'(SCREEN_W)) &&
                (sy < (YW+1)'(SCREEN_H));
    end
  end

  // State, snapshot, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cox_q    <= '0;
      coy_q    <= '0;
      cstyle_q <= '0;
      erase_q  <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      band_q   <= '0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      color_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cox_q    <= cox_d;
      coy_q    <= coy_d;
      cstyle_q <= cstyle_d;
      erase_q  <= erase_d;
      col_q    <= col_d;
      row_q    <= row_d;
      band_q   <= band_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      color_q  <= color_d;
      done_q   <= done_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_FLOOR) || (state_q == ST_SPRITE);
  assign plot      = plot_q;
  assign x         = x_q;
  assign y         = y_q;
  assign color     = color_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine: a table of commands with
// hand-computed pixel counts, first/last pixels and timing, plus sequences
// for held requests, mid-command loads and mid-command reset.
module tb_sprite_draw_engine;
  import draw_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd3;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic       ld_pos = 1'b0;
  logic [0:0] style_in = '0;
  logic       ld_style = 1'b0;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;
  logic       busy;
  logic       done;

  sprite_draw_engine dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .x_in     (x_in),
    .y_in     (y_in),
    .ld_pos   (ld_pos),
    .style_in (style_in),
    .ld_style (ld_style),
    .plot     (plot),
    .x        (x),
    .y        (y),
    .color    (color),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op; int load; int ox; int oy; int st;
    int done_c; int plots;
    int fcyc; int fx; int fy; int lcyc; int lx; int ly;
    int col; int xmin; int xmax; int ymin; int ymax; int cmp;
  } vec_t;

  int total = 0;
  int bad = 0;
  int rec_done, rec_plots, rec_fcyc, rec_lcyc, rec_out, rec_badcol, rec_gap, rec_busy, rec_ready;
  int qx[$], qy[$], qcy[$];
  int rx[$], ry[$], rcy[$];
  int hook_kind = 0;
  int hook_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int ox, input int oy, input int st);
    @(negedge clk);
    x_in = 8'(ox); y_in = 7'(oy); style_in = 1'(st);
    ld_pos = 1'b1; ld_style = 1'b1;
    @(negedge clk);
    ld_pos = 1'b0; ld_style = 1'b0;
  endtask

  task automatic run(input int op, input logic hold, input int xmin, input int xmax,
                     input int ymin, input int ymax, input int col);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'(op);
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    rec_done = -1; rec_plots = 0; rec_fcyc = -1; rec_lcyc = -1; rec_out = 0;
    rec_badcol = 0; rec_gap = 0; rec_busy = 0; rec_ready = 0;
    qx.delete(); qy.delete(); qcy.delete();
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (plot) begin
        qx.push_back(int'(x)); qy.push_back(int'(y)); qcy.push_back(i);
        if (rec_plots == 0) rec_fcyc = i;
        rec_lcyc = i;
        rec_plots++;
        if (int'(x) < xmin || int'(x) > xmax || int'(y) < ymin || int'(y) > ymax) rec_out++;
        if (int'(color) != col) rec_badcol++;
        if ((y >= 40 && y <= 74) || (y >= 80 && y <= 114)) rec_gap++;
      end
      if (busy) rec_busy++;
      if (cmd_ready) rec_ready++;
      if (done) begin
        rec_done = i;
        cmd_valid = 1'b0;
        break;
      end
      if (hook_kind == 1 && i == hook_cyc) begin
        x_in = 8'd100; y_in = 7'd20; style_in = 1'b0; ld_pos = 1'b1; ld_style = 1'b1;
      end
      if (hook_kind == 1 && i == hook_cyc + 1) begin
        ld_pos = 1'b0; ld_style = 1'b0;
      end
      if (hook_kind == 2 && i == hook_cyc) begin
        #2 reset = 1'b1;
        #1;
        check("rst_mid_plot", int'(plot), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_ready", int'(cmd_ready), 1);
        check("rst_mid_x", int'(x), 0);
      end
      if (hook_kind == 2 && i == hook_cyc + 1) reset = 1'b0;
      if (hook_kind == 2 && i == hook_cyc + 80) break;
    end
    hook_kind = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    int mm;
    // op load ox oy st | done plots | fcyc fx fy | lcyc lx ly | col | window | cmp
    tbl[0]  = '{2, 0,  30, 108, 1,   65,   19,  3,  32, 108,   54,  35, 114, 0,  30,  37, 108, 115, 0};
    tbl[1]  = '{0, 0,   0,   0, 0, 2401, 2400,  1,   0,  35, 2400, 159, 119, 5,   0, 159,  35, 119, 0};
    tbl[2]  = '{1, 1,  30, 108, 1,   65,   19,  3,  32, 108,   54,  35, 114, 7,  30,  37, 108, 115, 0};
    tbl[3]  = '{2, 0,  30, 108, 1,   65,   19,  3,  32, 108,   54,  35, 114, 0,  30,  37, 108, 115, 1};
    tbl[4]  = '{1, 1,  30, 108, 0,   65,   22, 19,  32, 110,   55,  36, 114, 7,  30,  37, 108, 115, 0};
    tbl[5]  = '{1, 1, 156,  50, 1,   65,   12,  3, 158,  50,   50, 157,  56, 7, 156, 159,  50,  57, 0};
    tbl[6]  = '{1, 1,  10, 118, 1,   65,    6,  3,  12, 118,   13,  14, 119, 7,  10,  17, 118, 119, 0};
    tbl[7]  = '{2, 1, 156, 118, 0,   65,    0,  0,   0,   0,    0,   0,   0, 0,   0, 159,   0, 119, 0};
    tbl[8]  = '{1, 1, 250,  20, 1,   65,    0,  0,   0,   0,    0,   0,   0, 7,   0, 159,   0, 119, 0};
    tbl[9]  = '{1, 1,  20, 125, 1,   65,    0,  0,   0,   0,    0,   0,   0, 7,   0, 159,   0, 119, 0};
    tbl[10] = '{3, 0,   0,   0, 0,    1,    0,  0,   0,   0,    0,   0,   0, 0,   0, 159,   0, 119, 0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_xyc", int'({x, y, color}), 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", int'(cmd_ready), 1);
    check("post_rst_busy", int'(busy), 0);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].load != 0) load(tbl[i].ox, tbl[i].oy, tbl[i].st);
      run(tbl[i].op, 1'b0, tbl[i].xmin, tbl[i].xmax, tbl[i].ymin, tbl[i].ymax, tbl[i].col);
      check($sformatf("v%0d_done_cycle", i), rec_done, tbl[i].done_c);
      check($sformatf("v%0d_plots", i), rec_plots, tbl[i].plots);
      check($sformatf("v%0d_outside", i), rec_out, 0);
      check($sformatf("v%0d_color", i), rec_badcol, 0);
      check($sformatf("v%0d_busy_cycles", i), rec_busy, tbl[i].done_c - 1);
      check($sformatf("v%0d_ready_while_busy", i), rec_ready, 0);
      if (tbl[i].plots > 0 && rec_plots > 0) begin
        check($sformatf("v%0d_first_cyc", i), rec_fcyc, tbl[i].fcyc);
        check($sformatf("v%0d_first_x", i), qx[0], tbl[i].fx);
        check($sformatf("v%0d_first_y", i), qy[0], tbl[i].fy);
        check($sformatf("v%0d_last_cyc", i), rec_lcyc, tbl[i].lcyc);
        check($sformatf("v%0d_last_x", i), qx[qx.size()-1], tbl[i].lx);
        check($sformatf("v%0d_last_y", i), qy[qy.size()-1], tbl[i].ly);
      end
      if (tbl[i].op == 0) check($sformatf("v%0d_gap_rows", i), rec_gap, 0);
      if (tbl[i].cmp != 0) begin
        mm = 0;
        check($sformatf("v%0d_seq_len", i), qx.size(), rx.size());
        for (int k = 0; k < qx.size() && k < rx.size(); k++)
          if (qx[k] != rx[k] || qy[k] != ry[k] || qcy[k] != rcy[k]) mm++;
        check($sformatf("v%0d_seq_match", i), mm, 0);
      end
      if (i == 2) begin
        rx = qx; ry = qy; rcy = qcy;
      end
      @(negedge clk);
      check($sformatf("v%0d_ready_after", i), int'(cmd_ready), 1);
      check($sformatf("v%0d_done_pulse", i), int'(done), 0);
    end

    // cmd_valid held through a sprite command: nothing else is accepted.
    load(30, 108, 1);
    run(1, 1'b1, 30, 37, 108, 115, 7);
    check("hold_done_cycle", rec_done, 65);
    check("hold_plots", rec_plots, 19);
    check("hold_ready_low", rec_ready, 0);
    @(negedge clk);
    check("hold_idle_after", int'(cmd_ready), 1);
    @(negedge clk);
    check("hold_no_restart", int'(busy), 0);

    // Origin/style load mid-command leaves the running pixels untouched.
    hook_kind = 1; hook_cyc = 10;
    run(1, 1'b0, 30, 37, 108, 115, 7);
    check("ldmid_done_cycle", rec_done, 65);
    check("ldmid_plots", rec_plots, 19);
    mm = 0;
    for (int k = 0; k < qx.size() && k < rx.size(); k++)
      if (qx[k] != rx[k] || qy[k] != ry[k] || qcy[k] != rcy[k]) mm++;
    check("ldmid_seq_match", mm, 0);
    run(1, 1'b0, 100, 107, 20, 27, 7);
    check("ldnext_plots", rec_plots, 22);
    check("ldnext_first_x", (rec_plots > 0) ? qx[0] : -1, 102);
    check("ldnext_first_y", (rec_plots > 0) ? qy[0] : -1, 22);
    check("ldnext_first_cyc", rec_fcyc, 19);

    // Reset at pixel 20 of a sprite: no done pulse, engine returns idle.
    load(30, 108, 1);
    hook_kind = 2; hook_cyc = 20;
    run(1, 1'b0, 30, 37, 108, 115, 7);
    check("rstmid_no_done", rec_done, -1);
    check("rstmid_plots", rec_plots, 7);
    check("rstmid_ready", int'(cmd_ready), 1);
    // Reset restored the default origin (30,108) and normal style.
    run(2, 1'b0, 30, 37, 108, 115, 0);
    check("rstdef_plots", rec_plots, 19);
    check("rstdef_first_x", (rec_plots > 0) ? qx[0] : -1, 32);
    check("rstdef_first_y", (rec_plots > 0) ? qy[0] : -1, 108);
    check("rstdef_done_cycle", rec_done, 65);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
